// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable oversampling UART receiver.
//
// Receives one frame: a start bit, DATA_BITS data bits sent LSB first, an
// optional parity bit, and STOP_BITS stop bits. Each bit is sampled three
// times around its centre, and a 2-of-3 majority gives the bit value.
//
// Parameters:
//   CPB       clocks per bit (4..65535)
//   DATA_BITS data bits per frame (5..9)
//   PARITY    0 none, 1 odd, 2 even
//   STOP_BITS stop bits checked (1 or 2)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   rx         asynchronous serial line, idles high
//   rx_data    last received word
//   rx_done    one-cycle pulse when rx_data and the error flags are updated
//   parity_err parity mismatch in the last frame
//   frame_err  a stop bit in the last frame sampled low
//   break_det  one-cycle pulse on break detection
//   busy       high whenever the receiver is not idle
module uart_rx_cfg #(
    parameter int CPB       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Sample points around the bit centre. Integer division floors for odd CPB.
    localparam logic [15:0] CNT_S0   = 16'(CPB / 2 - 1);
    localparam logic [15:0] CNT_S1   = 16'(CPB / 2);
    localparam logic [15:0] CNT_DEC  = 16'(CPB / 2 + 1);
    localparam logic [15:0] CNT_LAST = 16'(CPB - 1);
    localparam logic [3:0]  IDX_LAST = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic [2:0]           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [3:0]           idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;

    logic maj;
    logic par_bad;

    // Majority is evaluated on the third sample cycle, using the two stored
    // samples together with the live synchronized line.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

    // Odd parity: data XOR parity bit must be 1; even: must be 0.
    always_comb begin
        par_bad = 1'b0;
        if (PARITY == 1)
            par_bad = ~(^shift_q ^ par_q);
        else if (PARITY == 2)
            par_bad = ^shift_q ^ par_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        samp_d     = samp_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_acc_d = ferr_acc_q;
        rx_data_d  = rx_data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        brk_d      = 1'b0;

        if (cnt_q == CNT_S0) samp_d[0] = rxs_q;
        if (cnt_q == CNT_S1) samp_d[1] = rxs_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = ST_START;
                    ferr_acc_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_DEC && maj) begin
                    // Line came back high: treat as a glitch.
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = 16'd0;
                    idx_d   = 4'd0;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_DEC)
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 16'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_DEC)
                    par_d = maj;
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_STOP;
                    cnt_d      = 16'd0;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_DEC) begin
                    if (!stop_idx_q && !maj && (shift_q == '0) &&
                        (PARITY == 0 || !par_q)) begin
                        state_d = ST_BREAK;
                        cnt_d   = 16'd0;
                        brk_d   = 1'b1;
                    end else if (stop_idx_q == STOP_LAST) begin
                        // Finish at the last decision, not the end of the bit,
                        // so a following start edge is never missed.
                        state_d   = ST_IDLE;
                        cnt_d     = 16'd0;
                        rx_data_d = shift_q;
                        perr_d    = par_bad;
                        ferr_d    = ferr_acc_q | ~maj;
                        done_d    = 1'b1;
                    end else begin
                        ferr_acc_d = ferr_acc_q | ~maj;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d      = 16'd0;
                    stop_idx_d = ~stop_idx_q;
                end
            end
            ST_BREAK: begin
                cnt_d = 16'd0;
                if (rxs_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            samp_q     <= 2'b11;
            idx_q      <= 4'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    logic [7:0] data_a, data_b;
    logic [8:0] data_c;
    logic done_a, perr_a, ferr_a, brk_a, busy_a;
    logic done_b, perr_b, ferr_b, brk_b, busy_b;
    logic done_c, perr_c, ferr_c, brk_c, busy_c;

    int tests  = 0;
    int failed = 0;
    int done_cnt_a = 0, brk_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0, brk_cnt_c = 0;

    always #5 clk = ~clk;

    // 8N1
    uart_rx_cfg #(.CPB(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_done(done_a),
        .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a));
    // 8E1
    uart_rx_cfg #(.CPB(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_done(done_b),
        .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b));
    // 9O2
    uart_rx_cfg #(.CPB(CPB), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx(rx_c), .rx_data(data_c), .rx_done(done_c),
        .parity_err(perr_c), .frame_err(ferr_c), .break_det(brk_c), .busy(busy_c));

    // Count cycles each pulse output is high.
    always @(posedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (brk_a)  brk_cnt_a  <= brk_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
        if (brk_c)  brk_cnt_c  <= brk_cnt_c + 1;
    end

    task automatic set_rx(input int which, input logic v);
        case (which)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nd,
                              input int has_par, input logic par, input logic stop0,
                              input int nstop);
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nd; i++) begin bits[n] = data[i]; n++; end
        if (has_par != 0) begin bits[n] = par; n++; end
        bits[n] = stop0; n++;
        if (nstop == 2) begin bits[n] = 1'b1; n++; end
        for (int i = 0; i < n; i++) begin
            set_rx(which, bits[i]);
            repeat (CPB) @(negedge clk);
        end
        set_rx(which, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({data_a, done_a, perr_a, ferr_a, brk_a, busy_a} !== 13'd0) begin
            failed++;
            $display("FAIL reset_a: outputs=%h required 0", {data_a, done_a, perr_a, ferr_a, brk_a, busy_a});
        end
        tests++;
        if ({data_c, done_c, busy_c} !== 11'd0) begin
            failed++;
            $display("FAIL reset_c: outputs=%h required 0", {data_c, done_c, busy_c});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_8n1;
        int d0;
        d0 = done_cnt_a;
        send_frame(0, 9'h05E, 8, 0, 1'b0, 1'b1, 1);
        @(negedge clk);
        tests++;
        if (data_a !== 8'h5E) begin failed++; $display("FAIL 8n1_data: got %h required 5e", data_a); end
        tests++;
        if (done_cnt_a - d0 != 1) begin failed++; $display("FAIL 8n1_done_width: got %0d cycles required 1", done_cnt_a - d0); end
        tests++;
        if ({perr_a, ferr_a, busy_a} !== 3'b000) begin failed++; $display("FAIL 8n1_flags: perr/ferr/busy=%b required 000", {perr_a, ferr_a, busy_a}); end
        $display("[TB] 8n1 frame 0x5e -> data=%h", data_a);
    endtask

    task automatic test_parity;
        int d0;
        d0 = done_cnt_b;
        send_frame(1, 9'h0A5, 8, 1, 1'b1, 1'b1, 1);
        @(negedge clk);
        tests++;
        if (data_b !== 8'hA5 || perr_b !== 1'b1 || ferr_b !== 1'b0) begin
            failed++; $display("FAIL parity_bad: data=%h perr=%b ferr=%b required a5 1 0", data_b, perr_b, ferr_b);
        end
        $display("[TB] even parity 0xa5 p=1 -> data=%h perr=%b", data_b, perr_b);
        send_frame(1, 9'h001, 8, 1, 1'b1, 1'b1, 1);
        @(negedge clk);
        tests++;
        if (data_b !== 8'h01 || perr_b !== 1'b0) begin
            failed++; $display("FAIL parity_good: data=%h perr=%b required 01 0", data_b, perr_b);
        end
        tests++;
        if (done_cnt_b - d0 != 2) begin failed++; $display("FAIL parity_done_count: got %0d required 2", done_cnt_b - d0); end
        $display("[TB] even parity 0x01 p=1 -> data=%h perr=%b", data_b, perr_b);
    endtask

    task automatic test_frame_break;
        int d0, b0;
        d0 = done_cnt_a;
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0, 1);
        @(negedge clk);
        tests++;
        if (data_a !== 8'h3C || ferr_a !== 1'b1 || done_cnt_a - d0 != 1) begin
            failed++; $display("FAIL frame_err: data=%h ferr=%b dones=%0d required 3c 1 1", data_a, ferr_a, done_cnt_a - d0);
        end
        $display("[TB] 0x3c stop=0 -> data=%h ferr=%b", data_a, ferr_a);
        repeat (2 * CPB) @(negedge clk);
        d0 = done_cnt_a;
        b0 = brk_cnt_a;
        rx_a = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        tests++;
        if (brk_cnt_a - b0 != 1 || done_cnt_a - d0 != 0) begin
            failed++; $display("FAIL break_pulse: breaks=%0d dones=%0d required 1 0", brk_cnt_a - b0, done_cnt_a - d0);
        end
        tests++;
        if (busy_a !== 1'b1 || data_a !== 8'h3C || ferr_a !== 1'b1) begin
            failed++; $display("FAIL break_hold: busy=%b data=%h ferr=%b required 1 3c 1", busy_a, data_a, ferr_a);
        end
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (busy_a !== 1'b0) begin failed++; $display("FAIL break_exit: busy=%b required 0", busy_a); end
        $display("[TB] break -> pulses=%0d busy_after=%b", brk_cnt_a - b0, busy_a);
    endtask

    task automatic test_glitch;
        int d0;
        d0 = done_cnt_a;
        rx_a = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        tests++;
        if (done_cnt_a - d0 != 0 || busy_a !== 1'b0) begin
            failed++; $display("FAIL glitch: dones=%0d busy=%b required 0 0", done_cnt_a - d0, busy_a);
        end
        send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 1);
        @(negedge clk);
        tests++;
        if (data_a !== 8'h81 || ferr_a !== 1'b0 || done_cnt_a - d0 != 1) begin
            failed++; $display("FAIL glitch_next: data=%h ferr=%b dones=%0d required 81 0 1", data_a, ferr_a, done_cnt_a - d0);
        end
        $display("[TB] glitch then 0x81 -> data=%h", data_a);
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt_c;
        send_frame(2, 9'h1FF, 9, 1, 1'b0, 1'b1, 2);
        tests++;
        if (data_c !== 9'h1FF || perr_c !== 1'b0 || ferr_c !== 1'b0) begin
            failed++; $display("FAIL b2b_first: data=%h perr=%b ferr=%b required 1ff 0 0", data_c, perr_c, ferr_c);
        end
        $display("[TB] 9O2 frame 0x1ff -> data=%h", data_c);
        send_frame(2, 9'h000, 9, 1, 1'b1, 1'b1, 2);
        @(negedge clk);
        tests++;
        if (data_c !== 9'h000 || perr_c !== 1'b0 || ferr_c !== 1'b0) begin
            failed++; $display("FAIL b2b_second: data=%h perr=%b ferr=%b required 000 0 0", data_c, perr_c, ferr_c);
        end
        tests++;
        if (done_cnt_c - d0 != 2 || brk_cnt_c != 0) begin
            failed++; $display("FAIL b2b_pulses: dones=%0d breaks=%0d required 2 0", done_cnt_c - d0, brk_cnt_c);
        end
        $display("[TB] 9O2 frame 0x000 -> data=%h", data_c);
    endtask

    task automatic test_reset_mid;
        int d0;
        logic [7:0] word;
        word = 8'h5E;
        d0 = done_cnt_a;
        rx_a = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_a = word[i];
            repeat (CPB) @(negedge clk);
        end
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({data_a, done_a, perr_a, ferr_a, brk_a, busy_a} !== 13'd0) begin
            failed++; $display("FAIL reset_async: outputs=%h required 0", {data_a, done_a, perr_a, ferr_a, brk_a, busy_a});
        end
        repeat (2) @(negedge clk);
        rx_a = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt_a - d0 != 0 || busy_a !== 1'b0) begin
            failed++; $display("FAIL reset_abort: dones=%0d busy=%b required 0 0", done_cnt_a - d0, busy_a);
        end
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 1);
        @(negedge clk);
        tests++;
        if (data_a !== 8'hC3 || ferr_a !== 1'b0 || done_cnt_a - d0 != 1) begin
            failed++; $display("FAIL reset_recover: data=%h ferr=%b dones=%0d required c3 0 1", data_a, ferr_a, done_cnt_a - d0);
        end
        $display("[TB] reset mid-frame then 0xc3 -> data=%h", data_a);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CPB, default 16, clocks per bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1, 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-008 SHALL have port rx_data, output, DATA_BITS, last received word, LSB first on the line.
REQ-009 SHALL have port rx_done, output, 1, one-cycle pulse when rx_data and the flags are updated.
REQ-010 SHALL have port parity_err, output, 1, parity mismatch in the last frame.
REQ-011 SHALL have port frame_err, output, 1, a stop bit in the last frame sampled low.
REQ-012 SHALL have port break_det, output, 1, one-cycle pulse on break detection.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized signal (rxs).
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 SHALL keep a bit-phase counter 0..CPB-1, cleared on every state or bit entry, and a bit index 0..DATA_BITS-1.
REQ-017 SHALL take the three samples of each bit at counts CPB/2-1, CPB/2, CPB/2+1 and decide by 2-of-3 majority at CPB/2+1.
REQ-018 IDLE: on rxs 1->0, SHALL enter START with the counter at 0.
REQ-019 START: majority 1 SHALL return to IDLE as a glitch, with no output change; majority 0 SHALL proceed to DATA at count CPB-1.
REQ-020 DATA: SHALL shift bits into the shift register LSB first; after bit DATA_BITS-1 it SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-021 PARITY: SHALL compare the received bit with the XOR of the data bits (odd: XOR of data plus parity = 1; even: = 0).
REQ-022 STOP: SHALL check STOP_BITS bits; any stop majority 0 sets frame_err for this frame.
REQ-023 SHALL, on the cycle after the decision for the last stop bit: load rx_data, load parity_err and frame_err, pulse rx_done for exactly 1 cycle, and enter IDLE without waiting for the end of the stop bit.
REQ-024 SHALL hold parity_err and frame_err at their loaded values until the next rx_done.
REQ-025 Break is defined as: all data bits 0, parity bit (if present) 0, and first stop bit 0.
REQ-026 On break, SHALL pulse break_det and assert no rx_done; rx_data and the flags SHALL keep their previous values.
REQ-027 After break, SHALL enter BREAK and stay there until rxs is 1, then go to IDLE.
REQ-028 A frame whose data is nonzero with stop = 0 SHALL be a normal frame with frame_err=1 and rx_done pulsed.
REQ-029 With CPB odd, CPB/2 SHALL use floor division.
REQ-030 rx_done and break_det SHALL never assert in the same cycle.

Reset
REQ-031 While rst=1: state IDLE; counters 0; synchronizer flops 1; rx_data 0; rx_done, parity_err, frame_err, break_det and busy 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no rx_done; after release, SHALL require rxs high then a falling edge before receiving.

Verification
REQ-033 CPB=16, 8N1: send 0x5E -> rx_data=0x5E, rx_done high exactly 1 cycle, parity_err=0, frame_err=0, busy low after.
REQ-034 PARITY=2: send 0xA5 with parity bit 1 (wrong) -> rx_done, rx_data=0xA5, parity_err=1; next frame 0x01 with parity 1 -> parity_err=0.
REQ-035 8N1: send 0x3C with stop bit 0 -> rx_done, rx_data=0x3C, frame_err=1; then break (rx low 20 bit times) -> break_det 1 pulse, no rx_done, busy high until rx rises.
REQ-036 rx low for CPB/4 cycles then high -> no rx_done, FSM back in IDLE, next 0x81 received correctly.
REQ-037 Assert rst during DATA of 0x5E -> all outputs 0 asynchronously, no rx_done; after release, 0xC3 received correctly.
REQ-038 DATA_BITS=9, STOP_BITS=2, PARITY=1: back-to-back 0x1FF, 0x000 -> two rx_done pulses, correct data, no errors.
